// File: rtl/ripple_adder.sv
// Unsigned WIDTH-bit ripple-carry adder built from full-adder cells,
// with sum and carry-out captured in an output register (one clock latency).

module ripple_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             Co
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    assign w_c[0] = 1'b0;

    // Carry ripples LSB to MSB; cell i's carry-out feeds cell i+1.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        ripple_adder_fa u_fa (
            .i_a (X[g]),
            .i_b (Y[g]),
            .i_c (w_c[g]),
            .o_s (w_s[g]),
            .o_c (w_c[g+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_s;
            r_co <= w_c[WIDTH];
        end
    end

    assign S  = r_s;
    assign Co = r_co;
endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder at WIDTH=4 and WIDTH=8.

module tb_ripple_adder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] x4 = '0, y4 = '0, s4;
    logic [7:0] x8 = '0, y8 = '0, s8;
    logic       co4, co8;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t t4[7];
    vec_t t8[4];

    ripple_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .X(x4), .Y(y4), .S(s4), .Co(co4)
    );
    ripple_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .X(x8), .Y(y8), .S(s8), .Co(co8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {Co,S}=0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp4;
        logic [8:0] exp8;
        logic [7:0] px, py;

        t4[0] = '{8'd0,  8'd0,  8'd0,  1'b0};
        t4[1] = '{8'd2,  8'd1,  8'd3,  1'b0};
        t4[2] = '{8'd15, 8'd6,  8'd5,  1'b1};
        t4[3] = '{8'd15, 8'd1,  8'd0,  1'b1};
        t4[4] = '{8'd15, 8'd15, 8'd14, 1'b1};
        t4[5] = '{8'd8,  8'd8,  8'd0,  1'b1};
        t4[6] = '{8'd7,  8'd8,  8'd15, 1'b0};
        t8[0] = '{8'd200, 8'd100, 8'd44,  1'b1};
        t8[1] = '{8'd255, 8'd1,   8'd0,   1'b1};
        t8[2] = '{8'd255, 8'd255, 8'd254, 1'b1};
        t8[3] = '{8'd100, 8'd27,  8'd127, 1'b0};

        // Asynchronous reset with no clock edge yet
        #1 reset = 1'b1;
        #1;
        chk("reset_async4", {4'd0, co4, s4}, 9'd0);
        chk("reset_async8", {co8, s8}, 9'd0);
        x4 = 4'd5; y4 = 4'd6;
        tick();
        chk("reset_hold4", {4'd0, co4, s4}, 9'd0);
        #2 reset = 1'b0;

        foreach (t4[i]) begin
            x4 = t4[i].x[3:0]; y4 = t4[i].y[3:0];
            tick();
            chk($sformatf("w4_vec%0d", i), {4'd0, co4, s4}, {4'd0, t4[i].co, t4[i].s[3:0]});
        end
        foreach (t8[i]) begin
            x8 = t8[i].x; y8 = t8[i].y;
            tick();
            chk($sformatf("w8_vec%0d", i), {co8, s8}, {t8[i].co, t8[i].s});
        end

        // Exhaustive sweep, new operands every cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                x4 = 4'(a); y4 = 4'(b);
                exp4 = 5'(a + b);
                tick();
                chk($sformatf("sweep_%0d_%0d", a, b), {4'd0, co4, s4}, {4'd0, exp4});
            end
        end

        // Random WIDTH=8 operands against plain arithmetic
        for (int i = 0; i < 200; i++) begin
            px = 8'($urandom); py = 8'($urandom);
            x8 = px; y8 = py;
            exp8 = 9'(int'(px) + int'(py));
            tick();
            chk($sformatf("rand8_%0d_%0d", px, py), {co8, s8}, exp8);
        end

        // Mid-operation reset pulse between edges
        x4 = 4'd9; y4 = 4'd9;
        tick();
        chk("mid_pre", {4'd0, co4, s4}, 9'h012);
        reset = 1'b1;
        #2;
        chk("mid_clear", {4'd0, co4, s4}, 9'd0);
        reset = 1'b0;
        #1;
        chk("mid_hold", {4'd0, co4, s4}, 9'd0);
        tick();
        chk("mid_after", {4'd0, co4, s4}, 9'h012);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
